seq_divider_16bit: RTL

Iterative 16-bit unsigned restoring divider for the CPU datapath. It computes quotient and remainder over 16 clock cycles. Each cycle it drives one trial subtraction through a private instance of the 16-bit add/sub unit and uses that unit's carry-out as the "no borrow" indication. Operands arrive on a valid/ready request channel and results leave on a valid/ready response channel, so the control unit can stall on either side.

---
 rtl/seq_divider_16bit_pkg.sv | 12 +
 rtl/seq_divider_16bit_math_unit.sv | 27 ++
 rtl/seq_divider_16bit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/seq_divider_16bit_pkg.sv
// Shared definitions for the iterative 16-bit divider: FSM encoding and datapath width.
package seq_divider_16bit_pkg;

    localparam int unsigned DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/seq_divider_16bit_math_unit.sv
// 16-bit add/subtract unit with carry-out, signed overflow, negative and zero flags.
module seq_divider_16bit_math_unit
    import seq_divider_16bit_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] a,
    input  logic [DIV_WIDTH-1:0] b,
    input  logic                 sub,
    output logic [DIV_WIDTH-1:0] sum,
    output logic                 cout,
    output logic                 overflow,
    output logic                 no,
    output logic                 zo
);

    logic [DIV_WIDTH-1:0] b_eff;

    // Subtraction is a + ~b + 1, so cout=1 means "no borrow".
    always_comb begin
        b_eff         = b ^ {DIV_WIDTH{sub}};
        {cout, sum}   = {1'b0, a} + {1'b0, b_eff} + {{DIV_WIDTH{1'b0}}, sub};
        overflow      = (a[DIV_WIDTH-1] == b_eff[DIV_WIDTH-1]) &&
                        (sum[DIV_WIDTH-1] != a[DIV_WIDTH-1]);
        no            = sum[DIV_WIDTH-1];
        zo            = (sum == '0);
    end

endmodule

// File: rtl/seq_divider_16bit.sv
// Iterative restoring divider: one trial subtraction per cycle, valid/ready on both sides.
module seq_divider_16bit
    import seq_divider_16bit_pkg::*;
#(
    parameter logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [DIV_WIDTH-1:0] dividend,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DIV_WIDTH-1:0] quotient,
    output logic [DIV_WIDTH-1:0] remainder,
    output logic                 div_by_zero,
    output logic                 busy
);

    div_state_e           state_q, state_d;
    logic [DIV_WIDTH-1:0] q_q, q_d, d_q, d_d, r_q, r_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 fin_q, fin_d;
    logic [DIV_WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
    logic                 dbz_q, dbz_d;

    logic [DIV_WIDTH-1:0] shift_rem, diff;
    logic                 cout, ok;
    logic                 unused_overflow, unused_no, unused_zo;

    assign shift_rem = {r_q[DIV_WIDTH-2:0], q_q[DIV_WIDTH-1]};
    // A set R[15] means the shifted remainder is >= 2^16 > D, so the subtract always fits.
    assign ok        = r_q[DIV_WIDTH-1] | cout;

    seq_divider_16bit_math_unit u_math_unit (
        .a        (shift_rem),
        .b        (d_q),
        .sub      (1'b1),
        .sum      (diff),
        .cout     (cout),
        .overflow (unused_overflow),
        .no       (unused_no),
        .zo       (unused_zo)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        fin_d   = fin_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (req_valid) begin
                    q_d   = dividend;
                    d_d   = divisor;
                    r_d   = '0;
                    fin_d = 1'b0;
                    if (divisor != '0) begin
                        state_d = DIV_RUN;
                        cnt_d   = 4'd15;
                    end else begin
                        state_d = DIV_DONE;
                        quo_d   = DIV0_QUOTIENT;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end
                end
            end
            DIV_RUN: begin
                // Extra cycle after the 16th iteration publishes the result registers.
                if (fin_q) begin
                    state_d = DIV_DONE;
                    fin_d   = 1'b0;
                    quo_d   = q_q;
                    rem_d   = r_q;
                    dbz_d   = 1'b0;
                end else begin
                    r_d = ok ? diff : shift_rem;
                    q_d = {q_q[DIV_WIDTH-2:0], ok};
                    if (cnt_q == 4'd0) begin
                        fin_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            DIV_DONE: begin
                if (rsp_ready) state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DIV_IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign req_ready   = (state_q == DIV_IDLE);
    assign rsp_valid   = (state_q == DIV_DONE);
    assign busy        = (state_q == DIV_RUN);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
